// File: rtl/pkfb_push_arbiter_if.sv
// Requester-side handshake and ASSP packet-FIFO push bus shared by the arbiter.
interface pkfb_push_arbiter_if #(
    parameter int unsigned NUM_REQ = 4
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [32*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]    req_last;
    logic [4*NUM_REQ-1:0]  req_fifo_sel;
    logic [NUM_REQ-1:0]    req_ready;
    logic [31:0]           FB_PKfbData;
    logic [3:0]            FB_PKfbPush;
    logic                  FB_PKfbSOF;
    logic                  FB_PKfbEOF;

    modport master (
        output req_valid, req_data, req_last, req_fifo_sel,
        input  req_ready, FB_PKfbData, FB_PKfbPush, FB_PKfbSOF, FB_PKfbEOF
    );

    modport slave (
        input  req_valid, req_data, req_last, req_fifo_sel,
        output req_ready, FB_PKfbData, FB_PKfbPush, FB_PKfbSOF, FB_PKfbEOF
    );
endinterface

// File: rtl/pkfb_push_arbiter.sv
// Round-robin packet arbiter onto the ASSP packet-FIFO push port, with SOF/EOF
// framing, truncation of over-long packets and sticky overflow/truncation flags.
module pkfb_push_arbiter #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned MAX_PKT_LEN = 256,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                   Sys_PKfb_Clk,
    input  logic                   Sys_PKfb_Rst,
    pkfb_push_arbiter_if.slave     bus,
    input  logic                   FB_PKfbOverflow,
    input  logic                   ovf_clr,
    output logic                   ovf_sticky,
    output logic                   trunc_sticky,
    output logic [2:0]             grant_id,
    output logic                   busy
);
    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, STREAM, DROP} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [3:0]         lane_q, lane_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        data_q, data_d;
    logic [3:0]         push_q, push_d;
    logic               sof_q, sof_d;
    logic               eof_q, eof_d;
    logic [NUM_REQ-1:0] ready_q, ready_d;
    logic               ovf_q, trunc_q;
    logic               trunc_set;

    logic               found;
    logic [IDX_W-1:0]   cand;
    logic               cur_valid;
    logic               cur_last;
    logic [31:0]        cur_word;
    logic               at_max;

    // Next-state, grant search and push-word formation.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        ptr_d     = ptr_q;
        lane_d    = lane_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        push_d    = '0;
        sof_d     = 1'b0;
        eof_d     = 1'b0;
        trunc_set = 1'b0;
        found     = 1'b0;
        cand      = '0;
        cur_valid = 1'b0;
        cur_last  = 1'b0;
        cur_word  = '0;
        at_max    = (cnt_q == CNT_W'(MAX_PKT_LEN - 1));

        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (grant_q == IDX_W'(i)) begin
                cur_valid = bus.req_valid[i];
                cur_last  = bus.req_last[i];
                cur_word  = bus.req_data[32*i +: 32];
            end
        end

        unique case (state_q)
            IDLE: begin
                for (int k = 0; k < int'(NUM_REQ); k++) begin
                    cand = IDX_W'((int'(ptr_q) + k) % int'(NUM_REQ));
                    if (!found && bus.req_valid[cand]) begin
                        found   = 1'b1;
                        grant_d = cand;
                    end
                end
                if (found) begin
                    for (int i = 0; i < int'(NUM_REQ); i++) begin
                        if (grant_d == IDX_W'(i)) lane_d = bus.req_fifo_sel[4*i +: 4];
                    end
                    ptr_d   = IDX_W'((int'(grant_d) + 1) % int'(NUM_REQ));
                    cnt_d   = '0;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (cur_valid) begin
                    data_d = cur_word;
                    push_d = lane_q;
                    sof_d  = (cnt_q == '0);
                    eof_d  = cur_last | at_max;
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (cur_last) begin
                        state_d = IDLE;
                    end else if (at_max) begin
                        trunc_set = 1'b1;
                        state_d   = DROP;
                    end
                end
            end
            DROP: begin
                if (cur_valid && cur_last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Ready is a pure decode of the next grant; no backpressure from the FIFO.
        ready_d = (state_d != IDLE) ? (NUM_REQ'(1) << grant_d) : '0;
    end

    always_ff @(posedge Sys_PKfb_Clk) begin
        if (Sys_PKfb_Rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            lane_q  <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            push_q  <= '0;
            sof_q   <= 1'b0;
            eof_q   <= 1'b0;
            ready_q <= '0;
            ovf_q   <= 1'b0;
            trunc_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            lane_q  <= lane_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            push_q  <= push_d;
            sof_q   <= sof_d;
            eof_q   <= eof_d;
            ready_q <= ready_d;
            // A new event wins over a coincident clear.
            ovf_q   <= FB_PKfbOverflow | (ovf_q & ~ovf_clr);
            trunc_q <= trunc_set | (trunc_q & ~ovf_clr);
        end
    end

    assign bus.FB_PKfbData = data_q;
    assign bus.FB_PKfbPush = push_q;
    assign bus.FB_PKfbSOF  = sof_q;
    assign bus.FB_PKfbEOF  = eof_q;
    assign bus.req_ready   = ready_q;
    assign ovf_sticky      = ovf_q;
    assign trunc_sticky    = trunc_q;
    assign grant_id        = 3'(grant_q);
    assign busy            = (state_q != IDLE);
endmodule

// File: tb/tb_pkfb_push_arbiter.sv
// Directed bench for pkfb_push_arbiter: a packet-level model checked every cycle,
// plus literal expectations taken from hand-worked traces.
module tb_pkfb_push_arbiter;
    localparam int N    = 4;
    localparam int MAXL = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       ovf_in;
    logic       ovf_clr;
    logic       ovf_sticky;
    logic       trunc_sticky;
    logic [2:0] grant_id;
    logic       busy;

    pkfb_push_arbiter_if #(.NUM_REQ(N)) bus();

    pkfb_push_arbiter #(.NUM_REQ(N), .MAX_PKT_LEN(MAXL), .CNT_W(16)) dut (
        .Sys_PKfb_Clk   (clk),
        .Sys_PKfb_Rst   (rst),
        .bus            (bus),
        .FB_PKfbOverflow(ovf_in),
        .ovf_clr        (ovf_clr),
        .ovf_sticky     (ovf_sticky),
        .trunc_sticky   (trunc_sticky),
        .grant_id       (grant_id),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    // Packet-level model: who owns the port, how many words it has sent, whether it is being dropped.
    int         m_owner = -1;
    int         m_grant = 0;
    int         m_ptr   = 0;
    int         m_count = 0;
    bit         m_drop  = 1'b0;
    logic [3:0] m_lane  = '0;
    logic [3:0] m_push  = '0;
    logic [31:0] m_data = '0;
    bit         m_sof = 1'b0, m_eof = 1'b0, m_ovf = 1'b0, m_trunc = 1'b0;
    bit         m_ok  = 1'b0;

    task automatic model_advance();
        bit t_ev;
        bit lst;
        t_ev = 1'b0;
        if (rst) begin
            m_owner = -1; m_grant = 0; m_ptr = 0; m_count = 0; m_drop = 1'b0;
            m_lane = '0; m_push = '0; m_data = '0;
            m_sof = 1'b0; m_eof = 1'b0; m_ovf = 1'b0; m_trunc = 1'b0;
            return;
        end
        m_push = '0; m_sof = 1'b0; m_eof = 1'b0;
        if (m_owner < 0) begin
            for (int k = 0; k < N; k++) begin
                int c;
                c = (m_ptr + k) % N;
                if (bus.req_valid[c]) begin
                    m_owner = c; m_grant = c;
                    m_lane  = bus.req_fifo_sel[4*c +: 4];
                    m_ptr   = (c + 1) % N;
                    m_count = 0; m_drop = 1'b0;
                    break;
                end
            end
        end else if (bus.req_valid[m_owner]) begin
            lst = bus.req_last[m_owner];
            if (!m_drop) begin
                m_data = bus.req_data[32*m_owner +: 32];
                m_push = m_lane;
                m_sof  = (m_count == 0);
                m_eof  = lst || (m_count == MAXL - 1);
                if (!lst && m_count == MAXL - 1) begin
                    t_ev = 1'b1; m_drop = 1'b1;
                end
            end
            m_count++;
            if (lst) m_owner = -1;
        end
        m_ovf   = ovf_in | (m_ovf & !ovf_clr);
        m_trunc = t_ev | (m_trunc & !ovf_clr);
    endtask

    // Per-cycle compare against the model, then advance it with the inputs of the coming edge.
    initial begin
        forever begin
            @(negedge clk);
            if (m_ok) begin
                logic [N-1:0] exp_ready;
                exp_ready = (m_owner >= 0) ? N'(1 << m_owner) : '0;
                chk("m_busy",  busy, (m_owner >= 0));
                chk("m_ready", bus.req_ready, exp_ready);
                chk("m_push",  bus.FB_PKfbPush, m_push);
                chk("m_data",  bus.FB_PKfbData, m_data);
                chk("m_sof",   bus.FB_PKfbSOF, m_sof);
                chk("m_eof",   bus.FB_PKfbEOF, m_eof);
                chk("m_grant", grant_id, 3'(m_grant));
                chk("m_ovf",   ovf_sticky, m_ovf);
                chk("m_trunc", trunc_sticky, m_trunc);
            end
            model_advance();
            m_ok = 1'b1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input bit v, input logic [31:0] d, input bit l);
        bus.req_valid[r]         = v;
        bus.req_last[r]          = l;
        bus.req_data[32*r +: 32] = d;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
    endtask

    int g_exp [5] = '{0, 1, 2, 3, 0};

    initial begin
        rst = 1'b1; ovf_in = 1'b0; ovf_clr = 1'b0;
        bus.req_valid = '0; bus.req_last = '0; bus.req_data = '0; bus.req_fifo_sel = '0;
        repeat (3) step();
        rst = 1'b0;
        chk("rst_grant", grant_id, 3'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_push", bus.FB_PKfbPush, 4'd0);
        chk("rst_sticky", {ovf_sticky, trunc_sticky}, 2'b00);

        // 1: three-word packet from requester 0 onto lane 1
        bus.req_fifo_sel[3:0] = 4'b0010;
        set_req(0, 1'b1, 32'hA0, 1'b0);
        step();
        chk("t1_ready", bus.req_ready, 4'b0001);
        step();
        chk("t1_w0", {bus.FB_PKfbData, bus.FB_PKfbPush, bus.FB_PKfbSOF, bus.FB_PKfbEOF}, {32'hA0, 4'b0010, 2'b10});
        set_req(0, 1'b1, 32'hA1, 1'b0);
        step();
        chk("t1_w1", {bus.FB_PKfbData, bus.FB_PKfbPush, bus.FB_PKfbSOF, bus.FB_PKfbEOF}, {32'hA1, 4'b0010, 2'b00});
        set_req(0, 1'b1, 32'hA2, 1'b1);
        step();
        chk("t1_w2", {bus.FB_PKfbData, bus.FB_PKfbPush, bus.FB_PKfbSOF, bus.FB_PKfbEOF}, {32'hA2, 4'b0010, 2'b01});
        chk("t1_idle", busy, 1'b0);
        set_req(0, 1'b0, 32'h0, 1'b0);
        step();

        // 2: all requesters with single-word packets, round-robin from 0
        do_reset();
        for (int r = 0; r < N; r++) begin
            bus.req_fifo_sel[4*r +: 4] = 4'(1 << r);
            set_req(r, 1'b1, 32'hD0 + r, 1'b1);
        end
        for (int g = 0; g < 5; g++) begin
            step();
            chk("t2_grant", grant_id, 3'(g_exp[g]));
            step();
            chk("t2_push", {bus.FB_PKfbData, bus.FB_PKfbPush, bus.FB_PKfbSOF, bus.FB_PKfbEOF, busy},
                {32'hD0 + g_exp[g], 4'(1 << g_exp[g]), 3'b110});
        end
        bus.req_valid = '0; bus.req_last = '0;
        step();

        // 3: requester 2 sends six words; only four are pushed
        bus.req_fifo_sel[11:8] = 4'b0100;
        set_req(2, 1'b1, 32'hB0, 1'b0);
        step();
        for (int w = 0; w < 6; w++) begin
            set_req(2, 1'b1, 32'hB0 + w, (w == 5));
            step();
            if (w < 4)
                chk("t3_push", {bus.FB_PKfbData, bus.FB_PKfbPush, bus.FB_PKfbEOF}, {32'hB0 + w, 4'b0100, (w == 3)});
            else
                chk("t3_drop", bus.FB_PKfbPush, 4'b0000);
            if (w == 3) chk("t3_trunc", trunc_sticky, 1'b1);
        end
        chk("t3_idle", busy, 1'b0);
        set_req(2, 1'b0, 32'h0, 1'b0);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("t3_clr", trunc_sticky, 1'b0);

        // 4: overflow pulse during a stream, clear, then clear racing a new pulse
        bus.req_fifo_sel[15:12] = 4'b1000;
        set_req(3, 1'b1, 32'hE0, 1'b0);
        step();
        step();
        set_req(3, 1'b1, 32'hE1, 1'b0);
        ovf_in = 1'b1;
        step();
        ovf_in = 1'b0;
        chk("t4_ovf", {ovf_sticky, bus.FB_PKfbData, bus.FB_PKfbPush}, {1'b1, 32'hE1, 4'b1000});
        set_req(3, 1'b1, 32'hE2, 1'b1);
        step();
        chk("t4_eof", {bus.FB_PKfbData, bus.FB_PKfbEOF, ovf_sticky}, {32'hE2, 2'b11});
        set_req(3, 1'b0, 32'h0, 1'b0);
        ovf_clr = 1'b1;
        step();
        chk("t4_clr", ovf_sticky, 1'b0);
        ovf_in = 1'b1;
        step();
        chk("t4_setwins", ovf_sticky, 1'b1);
        ovf_in = 1'b0;
        step();
        ovf_clr = 1'b0;
        chk("t4_clr2", ovf_sticky, 1'b0);

        // 5: reset after word 2 of 5, then a fresh packet from requester 0
        bus.req_fifo_sel[3:0] = 4'b0001;
        set_req(0, 1'b1, 32'hC0, 1'b0);
        step();
        step();
        set_req(0, 1'b1, 32'hC1, 1'b0);
        step();
        set_req(0, 1'b1, 32'hC2, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t5_rst", {busy, bus.req_ready, bus.FB_PKfbData, bus.FB_PKfbPush, bus.FB_PKfbSOF, bus.FB_PKfbEOF, grant_id},
            48'h0);
        set_req(0, 1'b1, 32'hF0, 1'b0);
        step();
        step();
        chk("t5_sof", {bus.FB_PKfbData, bus.FB_PKfbSOF, bus.FB_PKfbEOF}, {32'hF0, 2'b10});
        set_req(0, 1'b1, 32'hF1, 1'b1);
        step();
        chk("t5_eof", {bus.FB_PKfbData, bus.FB_PKfbSOF, bus.FB_PKfbEOF}, {32'hF1, 2'b01});
        set_req(0, 1'b0, 32'h0, 1'b0);
        step();

        // 6: lane 0 on requester 1: words consumed, nothing pushed
        bus.req_fifo_sel[7:4] = 4'b0000;
        set_req(1, 1'b1, 32'h51, 1'b0);
        step();
        chk("t6_ready", bus.req_ready, 4'b0010);
        step();
        chk("t6_w0", {bus.FB_PKfbPush, bus.req_ready}, {4'b0000, 4'b0010});
        set_req(1, 1'b1, 32'h52, 1'b1);
        step();
        chk("t6_w1", {bus.FB_PKfbPush, busy}, {4'b0000, 1'b0});
        set_req(1, 1'b0, 32'h0, 1'b0);
        repeat (3) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
